// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM encoding and byte-lane masks for the load/store unit.
// Build option LSU_MISALIGN_ERR_EN is consumed by lsu_mem_port.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RESP      = 2'd2
  } lsu_state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // Accesses that cannot be served inside one aligned word, plus undefined funct3.
  function automatic logic access_bad(logic [2:0] f3, logic [1:0] off);
    logic bad;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = (off == 2'd3);
      F3_W:        bad = (off != 2'd0);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store mask/shift on the request side and
// load extract/extend on the return side.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_we_o,
  output logic [31:0] st_data_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_we_o   = MASK_NONE;
    st_data_o = st_data_i;
    case (st_funct3_i)
      F3_B: begin
        st_we_o   = MASK_B << st_off_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      F3_H: begin
        if (st_off_i != 2'd3) begin
          st_we_o   = MASK_H << st_off_i;
          st_data_o = st_data_i << {st_off_i, 3'b000};
        end
      end
      F3_W: begin
        if (st_off_i == 2'd0) st_we_o = MASK_W;
      end
      default: ;
    endcase
  end

  assign ld_shifted = ld_data_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = '0;
    case (ld_funct3_i)
      F3_B:  ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU: ld_data_o = {24'b0, ld_shifted[7:0]};
      F3_H:  if (ld_off_i != 2'd3) ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU: if (ld_off_i != 2'd3) ld_data_o = {16'b0, ld_shifted[15:0]};
      F3_W:  if (ld_off_i == 2'd0) ld_data_o = ld_shifted;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory-side load/store unit in front of a 1-cycle synchronous-read dmem.
// Define LSU_MISALIGN_ERR_EN to report misaligned/illegal accesses on rsp_err.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_W = 14,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   mem_en,
  output logic [3:0]             mem_we,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata
);

  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("lsu_mem_port supports RD_LATENCY == 1 only");
  end

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept;
  logic [3:0]  st_we;
  logic [31:0] ld_data;

  // Bits above the dmem window belong to the external address decoder.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:DMEM_ADDR_W+2];

  lsu_lane_align u_lane_align (
    .st_funct3_i (req_funct3),
    .st_off_i    (req_addr[1:0]),
    .st_data_i   (req_wdata),
    .st_we_o     (st_we),
    .st_data_o   (mem_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_data_i   (mem_rdata),
    .ld_data_o   (ld_data)
  );

  assign accept    = req_valid & (state_q == ST_IDLE);
  assign mem_en    = accept;
  assign mem_we    = (accept & req_we) ? st_we : MASK_NONE;
  assign mem_addr  = req_addr[DMEM_ADDR_W+1:2];
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    f3_d      = f3_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          off_d = req_addr[1:0];
          f3_d  = req_funct3;
          if (req_we) begin
            rdata_d = '0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        rdata_d = ld_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LSU_MISALIGN_ERR_EN
  logic err_q, err_d;

  assign err_d   = accept ? access_bad(req_funct3, req_addr[1:0]) : err_q;
  assign rsp_err = err_q & (state_q == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed requests push expected responses,
// a negedge monitor checks every presented response against the queue head.
module tb_lsu_mem_port;

  localparam int AW = 14;
`ifdef LSU_MISALIGN_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  logic [31:0] mem [0:(1<<AW)-1];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_hs = 0;
  int last_drive = 0;
  bit seen = 1'b0;

  lsu_mem_port #(.DMEM_ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous-read data memory with byte enables.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("rsp_latency", cycle - q[0].acc, q[0].lat);
        end
        chk("rsp_rdata", rsp_rdata, q[0].rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
        if (rsp_ready) begin
          chk("req_ready_in_hs", {31'b0, req_ready}, 32'd0);
          last_hs = cycle;
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] exp_we,
                       input logic [31:0] exp_rd, input logic exp_err, input bit track);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    chk("mem_en", {31'b0, mem_en}, 32'd1);
    chk("mem_we", {28'b0, mem_we}, {28'b0, exp_we});
    chk("mem_addr", {18'b0, mem_addr}, {18'b0, addr[15:2]});
    if (track) q.push_back('{exp_rd, exp_err, cycle, (we ? 1 : 2)});
    last_drive = cycle;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0] = 32'h80FF_1234;
    mem[1] = 32'hAABB_CCDD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Byte and halfword loads from mem[0] = 80FF_1234.
    issue(1'b0, 3'b000, 32'h3, '0, 4'b0000, 32'hFFFF_FF80, 1'b0, 1'b1);
    issue(1'b0, 3'b100, 32'h3, '0, 4'b0000, 32'h0000_0080, 1'b0, 1'b1);
    issue(1'b0, 3'b000, 32'h0, '0, 4'b0000, 32'h0000_0034, 1'b0, 1'b1);
    issue(1'b0, 3'b001, 32'h2, '0, 4'b0000, 32'hFFFF_80FF, 1'b0, 1'b1);
    issue(1'b0, 3'b101, 32'h1, '0, 4'b0000, 32'h0000_FF12, 1'b0, 1'b1);

    // SH into upper half of mem[1].
    issue(1'b1, 3'b001, 32'h6, 32'h1122_3344, 4'b1100, 32'h0, 1'b0, 1'b1);
    chk("sh_wdata", mem_wdata, 32'h3344_0000);
    drain();
    chk("sh_mem1", mem[1], 32'h3344_CCDD);

    // SB into lane 1 of mem[7]; upper address bits must be ignored.
    issue(1'b1, 3'b000, 32'h8000_001D, 32'hAABB_CCDD, 4'b0010, 32'h0, 1'b0, 1'b1);
    chk("sb_lane1", {24'b0, mem_wdata[15:8]}, 32'h0000_00DD);
    drain();
    chk("sb_mem7", mem[7], 32'h0000_DD00);

    // Misaligned accesses: no write, zero data, error only when enabled.
    issue(1'b0, 3'b001, 32'h3, '0, 4'b0000, 32'h0, ErrEn, 1'b1);
    issue(1'b1, 3'b010, 32'h5, 32'hDEAD_BEEF, 4'b0000, 32'h0, ErrEn, 1'b1);
    issue(1'b0, 3'b011, 32'h0, '0, 4'b0000, 32'h0, ErrEn, 1'b1);
    drain();
    chk("sw_mis_mem1", mem[1], 32'h3344_CCDD);

    // LW with response back-pressure.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h0, '0, 4'b0000, 32'h80FF_1234, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // Reset pulse while a load is in LOAD_WAIT drops the response.
    issue(1'b0, 3'b010, 32'h4, '0, 4'b0000, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstlw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rstlw_mem_we", {28'b0, mem_we}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rstlw_hold_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rstlw_hold_we", {28'b0, mem_we}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstlw_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rstlw_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end

    // Back-to-back SW then LW to the same word.
    issue(1'b1, 3'b010, 32'h8, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 3'b010, 32'h8, '0, 4'b0000, 32'h1122_3344, 1'b0, 1'b1);
    chk("b2b_accept_gap", last_drive - last_hs, 32'd1);
    drain();
    chk("sw_mem2", mem[2], 32'h1122_3344);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-side load/store unit between the Riscv151 datapath and the synchronous-read data memory (`dmem`).
- Turns byte, half and word load/store requests into a word address, a byte write-enable and lane-shifted write data.
- Extracts and sign/zero-extends load data on return.
- Produces exactly the register and `dmem` results the assembly bench checks: LB/LBU/LH/LHU/LW and SB/SH/SW.

Parameters:
- DMEM_ADDR_W, 14, word-address width of `dmem`; byte address bits [DMEM_ADDR_W+1:2] select the word.
- RD_LATENCY, 1, `dmem` read latency in cycles; only 1 is supported, checked at elaboration.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  response present
- rsp_ready  in  1  pipeline accepts response
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned/illegal access flag (see Optional Feature)
- mem_en  out  1  `dmem` enable
- mem_we  out  4  `dmem` byte write enables
- mem_addr  out  DMEM_ADDR_W  `dmem` word address
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  `dmem` read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset (async, rst_n=0), outputs:
  - state=IDLE
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - mem_en=0, mem_we=0
  - req_ready=1 after release
- States:
  - IDLE: req_ready=1.
  - LOAD_WAIT: req_ready=0; waits one cycle for mem_rdata.
  - RESP: req_ready=0; rsp_valid=1.
- Accept = req_valid & req_ready.
- On accept, in the same cycle and combinationally:
  - mem_en=1, mem_addr=req_addr[DMEM_ADDR_W+1:2].
  - Store: mem_we and mem_wdata asserted in this cycle; next state RESP.
  - Load: mem_we=0; next state LOAD_WAIT.
- Store lane rule (off=req_addr[1:0]):
  - SB: mem_we=1<<off, mem_wdata=wdata[7:0] replicated to all lanes.
  - SH, off in {0,1,2}: mem_we=4'b0011<<off, mem_wdata=wdata<<(8*off).
  - SH, off=3: mem_we=0.
  - SW, off=0: mem_we=4'b1111.
  - SW, off≠0: mem_we=0.
- Load extraction in LOAD_WAIT (off and funct3 registered at accept):
  - Shift mem_rdata right by 8*off.
  - B/BU: take [7:0], sign-extend for B, zero-extend for BU.
  - H/HU, off≤2: take [15:0], sign-extend for H, zero-extend for HU.
  - H/HU, off=3: result 0.
  - W: result is the word when off=0, 0 otherwise.
  - Result registered into rsp_rdata; next state RESP.
- Latency: load rsp_valid 2 cycles after accept; store rsp_valid 1 cycle after accept.
- RESP: rsp_valid, rsp_rdata and rsp_err held stable until rsp_ready=1, then IDLE.
  - No combinational path from rsp_ready to req_ready; the next request is accepted no earlier than the cycle after the handshake.
- Illegal funct3 (011, 110, 111): no write (mem_we=0), load result 0; treated as misaligned for rsp_err.
- Reset during LOAD_WAIT or RESP: response dropped; no spurious rsp_valid after reset release.
- Upper address bits above DMEM_ADDR_W+1 ignored; the address decoder outside this block handles MMIO.

Optional Feature:
- LSU_MISALIGN_ERR_EN defined:
  - rsp_err=1 in RESP for any misaligned H/W, off=3 halfword, or illegal funct3.
  - Registered at accept.
  - Memory side effects unchanged (no write, zero data).
- Not defined: rsp_err tied 0; behaviour otherwise identical.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (ST_IDLE, ST_LOAD_WAIT, ST_RESP)
  - byte-mask constants
- One natural sub-module, lsu_lane_align: purely combinational store-mask/shift and load extract/extend, driven by funct3 and off.
- lsu_mem_port keeps the FSM and registers.

Test Plan:
- mem[0]=0x80FF_1234; LB at off 3 -> rsp_rdata=0xFFFF_FF80. LBU at off 3 -> 0x0000_0080. LB at off 0 -> 0x0000_0034.
- mem[1]=0xAABB_CCDD; SH wdata 0x1122_3344 at byte addr 6 -> mem_we=4'b1100, mem[1]=0x3344_CCDD, rsp_valid exactly 1 cycle after accept.
- SB 0xAABB_CCDD at byte addr 0x1D -> mem_we=4'b0010, lane 1 = 0xDD. LH at off 3 -> rsp_rdata=0, no write, rsp_err=1 only with LSU_MISALIGN_ERR_EN.
- LW mem[0] with rsp_ready held low 3 cycles -> rsp_valid first at accept+2, rsp_rdata stable 0x80FF_1234 throughout, req_ready=0 until the cycle after the handshake.
- rst_n pulsed low in LOAD_WAIT -> rsp_valid=0 immediately, state IDLE, req_ready=1 after release, mem_we=0 throughout.
- Back-to-back SW 0x1122_3344 to addr 0x8 then LW addr 0x8 -> second request accepted cycle after the store response, load returns 0x1122_3344.
